// File: rtl/fifo_rd_dispatch.sv
`default_nettype none
// ============================================================================
// fifo_rd_dispatch : pops words from an upstream FIFO and routes each to one
//                    of four lanes chosen by its top two bits.
// Revision 1.0
// ============================================================================
module fifo_rd_dispatch #(
    parameter int DATA_SIZE = 6
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 enable,
    input  logic                 fifo_empty,
    input  logic [DATA_SIZE-1:0] fifo_data,
    input  logic [3:0]           lane_pause,
    output logic                 fifo_read,
    output logic [DATA_SIZE-1:0] data_out,
    output logic [3:0]           valid_out,
    output logic                 stall,
    output logic [7:0]           dispatch_count
);

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        READ    = 2'd1,
        CAPTURE = 2'd2,
        SEND    = 2'd3
    } state_t;

    state_t               state_q;
    logic [DATA_SIZE-1:0] hold_q;
    logic [DATA_SIZE-1:0] data_q;
    logic [3:0]           valid_q;
    logic [7:0]           count_q;

    logic [1:0]           w_sel;
    logic                 w_more;
    logic                 w_paused;

    assign w_sel    = hold_q[DATA_SIZE-1 -: 2];
    assign w_more   = enable && !fifo_empty;
    assign w_paused = lane_pause[w_sel];

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= IDLE;
            hold_q  <= '0;
            data_q  <= '0;
            valid_q <= '0;
            count_q <= '0;
        end else begin
            valid_q <= '0;
            case (state_q)
                IDLE: begin
                    if (w_more) state_q <= READ;
                end
                // READ always advances so a pop is never issued two cycles running
                READ: state_q <= CAPTURE;
                CAPTURE: begin
                    hold_q  <= fifo_data;
                    state_q <= SEND;
                end
                SEND: begin
                    if (!w_paused) begin
                        data_q  <= hold_q;
                        valid_q <= 4'b0001 << w_sel;
                        count_q <= count_q + 8'd1;
                        state_q <= w_more ? READ : IDLE;
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign fifo_read      = (state_q == READ);
    assign stall          = (state_q == SEND) && w_paused;
    assign data_out       = data_q;
    assign valid_out      = valid_q;
    assign dispatch_count = count_q;

endmodule
`default_nettype wire

// File: tb/tb_fifo_rd_dispatch.sv
`default_nettype none
// Directed bench for fifo_rd_dispatch with a queue-based upstream FIFO model.
module tb_fifo_rd_dispatch;

    logic       clk = 1'b0;
    logic       reset;
    logic       enable;
    logic       fifo_empty;
    logic [5:0] fifo_data;
    logic [3:0] lane_pause;
    logic       fifo_read;
    logic [5:0] data_out;
    logic [3:0] valid_out;
    logic       stall;
    logic [7:0] dispatch_count;

    int checks   = 0;
    int failures = 0;
    logic [5:0] fq[$];

    fifo_rd_dispatch #(.DATA_SIZE(6)) dut (
        .clk            (clk),
        .reset          (reset),
        .enable         (enable),
        .fifo_empty     (fifo_empty),
        .fifo_data      (fifo_data),
        .lane_pause     (lane_pause),
        .fifo_read      (fifo_read),
        .data_out       (data_out),
        .valid_out      (valid_out),
        .stall          (stall),
        .dispatch_count (dispatch_count)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // One clock; the FIFO model pops on the edge where fifo_read was high
    // and presents the word just after it.
    task automatic step();
        logic rd;
        rd = fifo_read;
        @(posedge clk);
        #1;
        if (rd && fq.size() > 0) fifo_data = fq.pop_front();
        fifo_empty = (fq.size() == 0);
    endtask

    task automatic push(input logic [5:0] v);
        fq.push_back(v);
        fifo_empty = 1'b0;
    endtask

    initial begin
        logic [5:0] words [4];
        int   n;
        logic prev_rd;
        words[0] = 6'h03; words[1] = 6'h14; words[2] = 6'h25; words[3] = 6'h36;

        reset = 1'b1; enable = 1'b0; fifo_empty = 1'b1;
        fifo_data = '0; lane_pause = '0;
        step(); step();
        chk("rst_valid", 32'(valid_out), 32'h0);
        chk("rst_data",  32'(data_out), 32'h0);
        chk("rst_count", 32'(dispatch_count), 32'h0);
        chk("rst_read",  32'(fifo_read), 32'h0);
        chk("rst_stall", 32'(stall), 32'h0);

        // Single word on lane 2
        reset = 1'b0; enable = 1'b1; push(6'h23);
        step(); chk("single_read", 32'(fifo_read), 32'h1);
        step(); chk("single_read_off", 32'(fifo_read), 32'h0);
        step(); chk("single_noval", 32'(valid_out), 32'h0);
        step();
        chk("single_valid", 32'(valid_out), 32'h4);
        chk("single_data",  32'(data_out), 32'h23);
        chk("single_count", 32'(dispatch_count), 32'h1);
        step();
        chk("single_pulse", 32'(valid_out), 32'h0);
        chk("single_hold",  32'(data_out), 32'h23);
        chk("single_idle",  32'(fifo_read), 32'h0);

        // Burst of four, one per lane, back-to-back
        for (int i = 0; i < 4; i++) push(words[i]);
        step();
        for (int i = 0; i < 4; i++) begin
            chk("burst_read", 32'(fifo_read), 32'h1);
            step(); chk("burst_cap", 32'(fifo_read), 32'h0);
            step(); chk("burst_send", 32'(valid_out), 32'h0);
            step();
            chk("burst_valid", 32'(valid_out), 32'(4'b0001 << i));
            chk("burst_data",  32'(data_out), 32'(words[i]));
            chk("burst_count", 32'(dispatch_count), 32'(2 + i));
        end
        chk("burst_idle", 32'(fifo_read), 32'h0);

        // Stall on lane 3 for five cycles, then release with other lanes paused
        lane_pause = 4'b1000; push(6'h31);
        step(); step(); step();
        for (int i = 0; i < 5; i++) begin
            chk("stall_hi",  32'(stall), 32'h1);
            chk("stall_nov", 32'(valid_out), 32'h0);
            chk("stall_nrd", 32'(fifo_read), 32'h0);
            if (i < 4) step();
        end
        lane_pause = 4'b0111;
        #1 chk("stall_drop", 32'(stall), 32'h0);
        step();
        chk("stall_valid", 32'(valid_out), 32'h8);
        chk("stall_data",  32'(data_out), 32'h31);
        chk("stall_count", 32'(dispatch_count), 32'h6);
        lane_pause = 4'b0000;

        // Enable falls during CAPTURE; word still goes out, then IDLE
        push(6'h12); push(6'h05);
        step(); chk("en_read", 32'(fifo_read), 32'h1);
        step(); enable = 1'b0;
        step();
        step();
        chk("en_valid", 32'(valid_out), 32'h2);
        chk("en_data",  32'(data_out), 32'h12);
        chk("en_count", 32'(dispatch_count), 32'h7);
        chk("en_noread", 32'(fifo_read), 32'h0);
        step();
        chk("en_noread2", 32'(fifo_read), 32'h0);
        chk("en_notempty", 32'(fifo_empty), 32'h0);

        // Drain the leftover word
        enable = 1'b1;
        step(); chk("drain_read", 32'(fifo_read), 32'h1);
        step(); step(); step();
        chk("drain_valid", 32'(valid_out), 32'h1);
        chk("drain_count", 32'(dispatch_count), 32'h8);

        // Reset while holding a paused word
        lane_pause = 4'b0100; push(6'h2A);
        step(); step(); step();
        chk("rsend_stall", 32'(stall), 32'h1);
        reset = 1'b1;
        step();
        chk("rsend_valid", 32'(valid_out), 32'h0);
        chk("rsend_data",  32'(data_out), 32'h0);
        chk("rsend_count", 32'(dispatch_count), 32'h0);
        chk("rsend_stall0", 32'(stall), 32'h0);
        chk("rsend_read",  32'(fifo_read), 32'h0);
        reset = 1'b0; lane_pause = 4'b0000;
        step(); step();
        chk("rsend_never", 32'(valid_out), 32'h0);
        chk("rsend_count2", 32'(dispatch_count), 32'h0);

        // Counter wrap over 256 dispatches
        for (int i = 0; i < 256; i++) push(6'h01);
        n = 0; prev_rd = 1'b0;
        for (int i = 0; i < 775; i++) begin
            step();
            if (valid_out != 4'b0000) n++;
            if (prev_rd && fifo_read) chk("wrap_b2b_read", 32'h1, 32'h0);
            prev_rd = fifo_read;
        end
        chk("wrap_n",     32'(n), 32'd256);
        chk("wrap_count", 32'(dispatch_count), 32'h0);
        push(6'h3F);
        step(); step(); step(); step();
        chk("wrap_valid",  32'(valid_out), 32'h8);
        chk("wrap_data",   32'(data_out), 32'h3F);
        chk("wrap_count1", 32'(dispatch_count), 32'h1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
`default_nettype wire
